// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between instruction fetch (port 0) and load/store (port 1).
// Latency: req sampled in IDLE at edge E0, RAM strobe during the next cycle, ack/err/rdata registered after edge E2; 3 cycles per transaction.
// Backpressure: a requester holds req until ack; a losing request waits in IDLE with no timeout.
//
// Ports:
//   clock, nreset          rising-edge clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN  port N request, held until ackN (N = 0 fetch, 1 load/store)
//   ackN/rdataN/errN       1-cycle completion pulse, read data (held afterwards), out-of-range flag
//   ramR/ramW/addr/dataW   RAM strobes, address and write data (active only in ACCESS)
//   dataR                  RAM read data, registered inside the RAM
//   busy                   FSM not in IDLE
//
// Build option: define RAM_ARB_ROUND_ROBIN_EN to alternate grants on contention.
// Without it, port 1 always wins over port 0 (last_gnt is tracked but not consulted).

module ram_arbiter #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              req0,
  input  logic              we0,
  input  logic [31:0]       addr0,
  input  logic [DWIDTH-1:0] wdata0,
  output logic              ack0,
  output logic [DWIDTH-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [31:0]       addr1,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              ack1,
  output logic [DWIDTH-1:0] rdata1,
  output logic              err1,
  output logic              ramR,
  output logic              ramW,
  output logic [31:0]       addr,
  output logic [DWIDTH-1:0] dataW,
  input  logic [DWIDTH-1:0] dataR,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               gnt_q, gnt_d;            // granted port index
  logic               last_gnt_q, last_gnt_d;
  logic               we_q, we_d;
  logic [31:0]        lat_addr_q, lat_addr_d;
  logic [DWIDTH-1:0]  lat_wdata_q, lat_wdata_d;
  logic               oor_q, oor_d;            // latched address is out of range
  logic               ramr_q, ramr_d;
  logic               ramw_q, ramw_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               err0_q, err0_d;
  logic               err1_q, err1_d;
  logic [DWIDTH-1:0]  rdata0_q, rdata0_d;
  logic [DWIDTH-1:0]  rdata1_q, rdata1_d;

  // Winner selection and the winner's request fields
  logic               pick1;
  logic               sel_we;
  logic [31:0]        sel_addr;
  logic [DWIDTH-1:0]  sel_wdata;
  logic               sel_oor;

  always_comb begin
    pick1 = req1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    // On contention hand the grant to the port that did not win last time.
    if (req0 && req1) begin
      pick1 = ~last_gnt_q;
    end
`endif
    sel_we    = pick1 ? we1    : we0;
    sel_addr  = pick1 ? addr1  : addr0;
    sel_wdata = pick1 ? wdata1 : wdata0;
    sel_oor   = (sel_addr >= 32'(DEPTH));
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    we_d        = we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    oor_d       = oor_q;
    ramr_d      = 1'b0;
    ramw_d      = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d       = pick1;
          we_d        = sel_we;
          lat_addr_d  = sel_addr;
          lat_wdata_d = sel_wdata;
          oor_d       = sel_oor;
          // Strobes are registered so they are clean for the whole ACCESS cycle;
          // an out-of-range address never reaches the RAM.
          ramr_d      = ~sel_we & ~sel_oor;
          ramw_d      =  sel_we & ~sel_oor;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
        // The RAM registered its read at the end of ACCESS, so dataR is valid now;
        // capturing it here lines rdata up with the registered ack.
        if (gnt_q) begin
          ack1_d = 1'b1;
          err1_d = oor_q;
          if (!we_q && !oor_q) begin
            rdata1_d = dataR;
          end
        end else begin
          ack0_d = 1'b1;
          err0_d = oor_q;
          if (!we_q && !oor_q) begin
            rdata0_d = dataR;
          end
        end
        last_gnt_d = gnt_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      we_q        <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      oor_q       <= 1'b0;
      ramr_q      <= 1'b0;
      ramw_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      we_q        <= we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      oor_q       <= oor_d;
      ramr_q      <= ramr_d;
      ramw_q      <= ramw_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Address and write data are only presented to the RAM during ACCESS.
  assign addr   = (state_q == ACCESS) ? lat_addr_q  : '0;
  assign dataW  = (state_q == ACCESS) ? lat_wdata_q : '0;
  assign ramR   = ramr_q;
  assign ramW   = ramw_q;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized scoreboard bench for ram_arbiter with a behavioural RAM attached.
// Latency: expects ack three clock edges after a request is raised into an idle arbiter.
// Backpressure: requesters hold req until ack, then drop it or present the next transaction.
`timescale 1ns/1ps
module tb_ram_arbiter;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clock  = 1'b0;
  logic          nreset = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0]   addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, err0, ack1, err1, ramR, ramW, busy;
  logic [DW-1:0] rdata0, rdata1, dataW;
  logic [DW-1:0] dataR = '0;
  logic [31:0]   addr;

  ram_arbiter #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .nreset(nreset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .ramR(ramR), .ramW(ramW), .addr(addr), .dataW(dataW),
    .dataR(dataR), .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural single-port RAM with registered read
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clock) begin
    if (ramW) ram_mem[addr[AW-1:0]] <= dataW;
    if (ramR) dataR <= ram_mem[addr[AW-1:0]];
  end

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t          exp_q[$];
  txn_t          plist0[$];
  txn_t          plist1[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_rd [2];
  int            n_cmp = 0, n_bad = 0;
  int            cyc = 0, last_ack_cyc = 0, round_start_cyc = 0;
  bit            round_first = 1'b0;
  int            n_r = 0, n_w = 0;
  bit            model_last = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc++;

  // Monitor: pops the expected transaction on every ack and checks it
  initial begin
    txn_t          t;
    logic          a, e, oor;
    logic [DW-1:0] r;
    forever begin
      @(posedge clock);
      #1;
      if (nreset) begin
        check("dual_ack", 64'(ack0 & ack1), 64'd0);
        check("strobe_excl", 64'(ramR & ramW), 64'd0);
        if (ramR || ramW) begin
          if (exp_q.size() == 0) begin
            check("strobe_unexpected", 64'(ramR | ramW), 64'd0);
          end else begin
            t = exp_q[0];
            check("strobe_we", 64'(ramW), 64'(t.we));
            check("strobe_addr", 64'(addr), 64'(t.addr));
            if (t.we) check("strobe_data", 64'(dataW), 64'(t.wdata));
            n_r = n_r + int'(ramR);
            n_w = n_w + int'(ramW);
          end
        end
        for (int p = 0; p < 2; p++) begin
          a = (p == 0) ? ack0 : ack1;
          e = (p == 0) ? err0 : err1;
          r = (p == 0) ? rdata0 : rdata1;
          if (a) begin
            if (exp_q.size() == 0) begin
              check("ack_unexpected", 64'(a), 64'd0);
            end else begin
              t = exp_q.pop_front();
              oor = (t.addr >= 32'(DEPTH));
              check("ack_port", 64'(p), 64'(t.port));
              check("err", 64'(e), 64'(oor));
              check("ramR_count", 64'(n_r), 64'(!t.we && !oor));
              check("ramW_count", 64'(n_w), 64'(t.we && !oor));
              if (!t.we && !oor) exp_rd[p] = ref_mem[t.addr[AW-1:0]];
              if (t.we && !oor) ref_mem[t.addr[AW-1:0]] = t.wdata;
              check("rdata", 64'(r), 64'(exp_rd[p]));
              if (round_first) check("first_latency", 64'(cyc - round_start_cyc), 64'd3);
              else             check("ack_spacing", 64'(cyc - last_ack_cyc), 64'd3);
              round_first  = 1'b0;
              last_ack_cyc = cyc;
              n_r = 0;
              n_w = 0;
            end
          end else begin
            check("err_idle", 64'(e), 64'd0);
            check("rdata_hold", 64'(r), 64'(exp_rd[p]));
          end
        end
      end
    end
  end

  task automatic drive(input int p, input logic rq, input logic w, input logic [31:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req0 = rq; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = rq; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // One requester: issues its list back-to-back, holding req between transactions
  task automatic run_port(input int p);
    txn_t t;
    int   n, budget;
    logic a;
    n = (p == 0) ? plist0.size() : plist1.size();
    for (int i = 0; i < n; i++) begin
      t = (p == 0) ? plist0[i] : plist1[i];
      drive(p, 1'b1, t.we, t.addr, t.wdata);
      budget = 0;
      do begin
        @(posedge clock);
        #1;
        budget++;
        a = (p == 0) ? ack0 : ack1;
      end while (!a && budget < 60);
      if (!a) check("ack_timeout", 64'(a), 64'd1);
    end
    drive(p, 1'b0, 1'b0, 32'd0, '0);
  endtask

  // Grant order follows the arbitration rule over the two pending lists
  task automatic do_round();
    int i0 = 0, i1 = 0, budget = 0;
    bit pick;
    while (i0 < plist0.size() || i1 < plist1.size()) begin
      if (i0 < plist0.size() && i1 < plist1.size()) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        pick = !model_last;
`else
        pick = 1'b1;
`endif
      end else begin
        pick = (i1 < plist1.size());
      end
      if (pick) exp_q.push_back(plist1[i1++]);
      else      exp_q.push_back(plist0[i0++]);
      model_last = pick;
    end
    @(negedge clock);
    round_start_cyc = cyc;
    round_first     = 1'b1;
    fork
      run_port(0);
      run_port(1);
    join
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge clock);
      #2;
      budget++;
    end
    if (exp_q.size() != 0) begin
      check("queue_drain", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    plist0.delete();
    plist1.delete();
  endtask

  function automatic txn_t mk(input int p, input logic w, input logic [31:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.port = p; t.we = w; t.addr = a; t.wdata = d;
    return t;
  endfunction

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel < 8) return 32'($urandom_range(0, DEPTH - 1));
    if (sel == 8) return 32'(DEPTH);
    return $urandom | 32'h8000_0000;
  endfunction

  initial begin
    int n0, n1;
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_ack0", 64'(ack0), 64'd0);
    check("rst_ack1", 64'(ack1), 64'd0);
    check("rst_err", 64'({err0, err1}), 64'd0);
    check("rst_rdata0", 64'(rdata0), 64'd0);
    check("rst_rdata1", 64'(rdata1), 64'd0);
    check("rst_strobes", 64'({ramR, ramW}), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_dataW", 64'(dataW), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);

    // Write then read, port 0
    plist0.push_back(mk(0, 1'b1, 32'd3, 32'hDEAD_BEEF));
    do_round();
    plist0.push_back(mk(0, 1'b0, 32'd3, '0));
    do_round();
    check("read_back_3", 64'(rdata0), 64'h0000_0000_DEAD_BEEF);

    // Simultaneous requests
    plist0.push_back(mk(0, 1'b0, 32'd1, '0));
    plist1.push_back(mk(1, 1'b0, 32'd2, '0));
    do_round();

    // Both ports requesting continuously, two each
    plist0.push_back(mk(0, 1'b0, 32'd4, '0));
    plist0.push_back(mk(0, 1'b1, 32'd5, 32'h1234_5678));
    plist1.push_back(mk(1, 1'b0, 32'd6, '0));
    plist1.push_back(mk(1, 1'b0, 32'd5, '0));
    do_round();

    // Out of range write, then a read of address 0
    plist1.push_back(mk(1, 1'b1, 32'd8, 32'hBAD0_BAD0));
    plist1.push_back(mk(1, 1'b0, 32'd0, '0));
    do_round();

    // Back-to-back reads on port 1
    plist1.push_back(mk(1, 1'b0, 32'd0, '0));
    plist1.push_back(mk(1, 1'b0, 32'd1, '0));
    plist1.push_back(mk(1, 1'b0, 32'd2, '0));
    do_round();

    // Asynchronous reset during ACCESS of a write
    exp_q.push_back(mk(0, 1'b1, 32'd5, 32'hCAFE_F00D));
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 32'd5, 32'hCAFE_F00D);
    @(posedge clock);
    #2;
    check("pre_rst_ramW", 64'(ramW), 64'd1);
    check("pre_rst_busy", 64'(busy), 64'd1);
    nreset = 1'b0;
    #1;
    check("arst_ramW", 64'(ramW), 64'd0);
    check("arst_ramR", 64'(ramR), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ack", 64'({ack0, ack1}), 64'd0);
    check("arst_rdata0", 64'(rdata0), 64'd0);
    drive(0, 1'b0, 1'b0, 32'd0, '0);
    exp_q.delete();
    n_r = 0;
    n_w = 0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    model_last = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    plist0.push_back(mk(0, 1'b0, 32'd5, '0));
    do_round();

    // Randomized rounds
    for (int k = 0; k < 40; k++) begin
      n0 = int'($urandom_range(0, 3));
      n1 = int'($urandom_range(0, 3));
      for (int i = 0; i < n0; i++) plist0.push_back(mk(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom));
      for (int i = 0; i < n1; i++) plist1.push_back(mk(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom));
      do_round();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter and sequencer for the single-port synchronous data RAM (`ram`, registered read, 1-cycle read latency).
- Shares the RAM between instruction fetch (port 0) and load/store unit (port 1).
- Drives the RAM's `ramR`, `ramW`, `addr` and `dataW` strobes directly, and returns read data through a req/ack handshake.
- Addresses beyond `DEPTH` are trapped without touching the RAM.

Parameters:
- DWIDTH, 32, data width; must match the RAM instance.
- DEPTH, 8, number of RAM words; valid addresses are 0..DEPTH-1.

Ports:
- clock  in  1  system clock, rising edge
- nreset  in  1  asynchronous active-low reset
- req0  in  1  port 0 request; held with addr0/we0/wdata0 until ack0
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  32  port 0 word address
- wdata0  in  DWIDTH  port 0 write data
- ack0  out  1  port 0 transaction complete, 1-cycle pulse
- rdata0  out  DWIDTH  port 0 read data, valid with ack0, held afterwards
- err0  out  1  port 0 address out of range, valid with ack0
- req1, we1, addr1, wdata1, ack1, rdata1, err1: same as port 0, for port 1
- ramR  out  1  RAM read strobe
- ramW  out  1  RAM write strobe
- addr  out  32  RAM address
- dataW  out  DWIDTH  RAM write data
- dataR  in  DWIDTH  RAM read data; registered in the RAM
- busy  out  1  arbiter not in IDLE

Behaviour:
- Reset values: all outputs 0, including rdata0/1 and the RAM strobes. State = IDLE. last_gnt = 1.
- Reset mid-transaction aborts immediately: strobes drop asynchronously and no ack is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, choose the winner (arbitration below) at the clock edge. The winner's addr/we/wdata and the port index are latched into internal registers; go to ACCESS.
- IDLE with an out-of-range latched address (addr >= DEPTH): go to ACCESS with no strobes asserted; err is flagged in RESP.
- ACCESS: lasts exactly 1 cycle.
  - Drives addr/dataW from the latched registers.
  - ramR = ~we, ramW = we, both registered.
  - Exactly one strobe is high, or none when out of range.
  - Next state is RESP.
- RESP: lasts exactly 1 cycle.
  - ackN = 1 for the granted port only.
  - Read: rdataN <= dataR, registered so it is valid in the ack cycle. Writes leave rdataN unchanged.
  - errN = 1 in this cycle if out of range; rdataN is unchanged in that case.
  - last_gnt <= granted port. Next state is always IDLE.
- Latency and throughput:
  - req sampled in IDLE at edge E0, ack high during the cycle after edge E2.
  - One transaction per 3 cycles maximum.
- Requester rules:
  - Must deassert req in the cycle after ack, or raise it again for a new transaction.
  - A req still high when the FSM returns to IDLE is treated as a new request.
- Arbitration without the optional feature: fixed priority; port 1 (data) wins over port 0 (fetch).
- The losing request stays pending; there is no timeout.
- Inputs are ignored outside IDLE; changes to a granted port's inputs after the grant have no effect.
- busy = (state != IDLE).
- Simultaneous ack: never; at most one ack per cycle.

Optional Feature:
- Macro: RAM_ARB_ROUND_ROBIN_EN.
- Defined: when both req are high in IDLE, grant the port != last_gnt. After reset port 0 wins the first contention. A single requester always wins regardless of last_gnt.
- Undefined: fixed priority port 1 > port 0. last_gnt is still maintained but unused.

Test Plan:
- Write then read, port 0:
  - req0, we0=1, addr0=3, wdata0=0xDEADBEEF -> ramW=1 with addr=3 one cycle after grant; ack0 2 cycles after sampling.
  - Then a read of addr 3 -> ramR pulse; ack0 with rdata0=0xDEADBEEF, err0=0.
- Contention, fixed priority (macro off):
  - req0 and req1 raised in the same cycle, reads of addr 1 and 2 -> port 1 acked first (rdata1=mem[2]).
  - Port 0 acked 3 cycles later (rdata0=mem[1]).
- Contention, round robin (macro on):
  - Both requesting continuously for 4 transactions -> ack order 0,1,0,1.
- Out of range:
  - req1, we1=1, addr1=8 with DEPTH=8 -> no ramR/ramW pulse; ack1=1 with err1=1; a following read of addr 0 is unchanged.
- Async reset mid-operation:
  - Assert nreset=0 during ACCESS -> ramW/ramR/busy/ack go 0 without waiting for a clock edge.
  - After release, the FSM is in IDLE and a fresh req is acked normally.
- Back-to-back, single port:
  - req1 held high across 3 reads of addr 0,1,2 -> ack1 every 3 cycles; rdata1 holds its value between acks.
